l2_tcdm_arbiter: RTL and testbench

- Two-master arbiter sharing the single L2 TCDM slave port (`l2_ram_multi_bank` mem_slave) between master 0 (the JTAG lint master) and master 1 (any second on-chip requester, e.g. a DMA).
- Supports a round-robin mode and a fixed-priority mode with an anti-starvation counter.
- Keeps the selected request stable while the slave has not yet granted it.
- Routes the one-cycle-later response back to the master that was granted.

---
 rtl/l2_tcdm_arbiter.sv | 117 +++++++++++
 tb/tb_l2_tcdm_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/l2_tcdm_arbiter.sv
// Two-master arbiter for the shared L2 TCDM slave port: round-robin or fixed
// priority with anti-starvation, request locking and response routing.
module l2_tcdm_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mode_rr_i,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_add_i,
  input  logic                    m0_wen_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  output logic                    m0_gnt_o,
  output logic                    m0_r_valid_o,
  output logic [DATA_WIDTH-1:0]   m0_r_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_add_i,
  input  logic                    m1_wen_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  output logic                    m1_gnt_o,
  output logic                    m1_r_valid_o,
  output logic [DATA_WIDTH-1:0]   m1_r_rdata_o,
  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_add_o,
  output logic                    s_wen_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  input  logic                    s_gnt_i,
  input  logic                    s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   s_r_rdata_i
);

  // A zero limit still gets a 1-bit counter so the register stays legal.
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic          rr_ptr;
  logic          lock_vld;
  logic          lock_id;
  logic          resp_vld;
  logic          resp_id;
  logic [CW-1:0] starve_cnt;
  logic          sel;
  logic          hs;
  logic          starved;

  assign starved = (STARVE_LIMIT > 0) && (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    sel = 1'b0;
    if (lock_vld)                  sel = lock_id;
    else if (m0_req_i && !m1_req_i) sel = 1'b0;
    else if (m1_req_i && !m0_req_i) sel = 1'b1;
    else if (m0_req_i && m1_req_i)  sel = mode_rr_i ? rr_ptr : starved;
  end

  always_comb begin
    s_req_o = lock_vld ? (lock_id ? m1_req_i : m0_req_i) : (m0_req_i | m1_req_i);
    if (sel) begin
      s_add_o   = m1_add_i;
      s_wen_o   = m1_wen_i;
      s_wdata_o = m1_wdata_i;
      s_be_o    = m1_be_i;
    end else begin
      s_add_o   = m0_add_i;
      s_wen_o   = m0_wen_i;
      s_wdata_o = m0_wdata_i;
      s_be_o    = m0_be_i;
    end
  end

  assign hs       = s_req_o & s_gnt_i;
  assign m0_gnt_o = hs & ~sel;
  assign m1_gnt_o = hs & sel;

  assign m0_r_valid_o = s_r_valid_i & resp_vld & ~resp_id;
  assign m1_r_valid_o = s_r_valid_i & resp_vld & resp_id;
  assign m0_r_rdata_o = s_r_rdata_i;
  assign m1_r_rdata_o = s_r_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      resp_vld <= 1'b0;
      resp_id  <= 1'b0;
    end else begin
      if (hs) begin
        lock_vld <= 1'b0;
      end else if (s_req_o) begin
        lock_vld <= 1'b1;
        lock_id  <= sel;
      end
      if (hs && mode_rr_i) rr_ptr <= ~sel;
      resp_vld <= hs;
      if (hs) resp_id <= sel;
    end
  end

  // Counter only runs in priority mode; an m1 handshake always wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (mode_rr_i || STARVE_LIMIT == 0) begin
      starve_cnt <= '0;
    end else if (hs && sel) begin
      starve_cnt <= '0;
    end else if (m1_req_i && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_l2_tcdm_arbiter.sv
// Directed, table-driven bench for l2_tcdm_arbiter (STARVE_LIMIT=4).
module tb_l2_tcdm_arbiter;

  localparam logic [31:0] A0 = 32'h1C00_0000;
  localparam logic [31:0] A1 = 32'h1C00_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_rr;
  logic        m0_req, m1_req, m0_wen, m1_wen;
  logic [31:0] m0_add, m1_add, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wen, s_gnt, s_rv;
  logic [31:0] s_add, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_tcdm_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_rr_i(mode_rr),
    .m0_req_i(m0_req), .m0_add_i(m0_add), .m0_wen_i(m0_wen), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_gnt_o(m0_gnt), .m0_r_valid_o(m0_rv), .m0_r_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_add_i(m1_add), .m1_wen_i(m1_wen), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_gnt_o(m1_gnt), .m1_r_valid_o(m1_rv), .m1_r_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_rv), .s_r_rdata_i(s_rdata)
  );

  typedef struct {
    logic        mode, r0, r1, gnt, rv;
    logic [31:0] rdata;
    logic        g0, g1, v0, v1, sreq;
    logic [31:0] sadd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic mode, r0, r1, gnt, rv, input logic [31:0] rdata,
                              input logic g0, g1, v0, v1, sreq, input logic [31:0] sadd);
    vec_t v;
    v.mode = mode; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.sreq = sreq; v.sadd = sadd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; s_gnt = 0; s_rv = 0; s_rdata = '0;
    m0_add = A0; m1_add = A1; m0_wen = 1; m1_wen = 1;
    m0_wdata = 32'h0000_0A0A; m1_wdata = 32'h0000_0B0B; m0_be = 4'hF; m1_be = 4'hF;
  endtask

  initial begin
    // mode r0 r1 gnt rv rdata | g0 g1 v0 v1 sreq sadd
    // RR alternation from reset (rr_ptr=0)
    vecs[0]  = mk(1,1,1,1,0,32'h0,        1,0,0,0,1,A0);
    vecs[1]  = mk(1,1,1,1,1,32'hD000_0001,0,1,1,0,1,A1);
    vecs[2]  = mk(1,1,1,1,1,32'hD000_0002,1,0,0,1,1,A0);
    vecs[3]  = mk(1,1,1,1,1,32'hD000_0003,0,1,1,0,1,A1);
    vecs[4]  = mk(1,0,0,0,1,32'hD000_0004,0,0,0,1,0,A0);
    // stray slave r_valid with nothing outstanding is dropped
    vecs[5]  = mk(1,0,0,0,1,32'hD000_0005,0,0,0,0,0,A0);
    // single master m0 read
    vecs[6]  = mk(1,1,0,1,0,32'h0,        1,0,0,0,1,A0);
    vecs[7]  = mk(1,0,0,0,1,32'hD000_0007,0,0,1,0,0,A0);
    // lock on m0 while m1 joins with rr_ptr=1
    vecs[8]  = mk(1,1,0,0,0,32'h0,        0,0,0,0,1,A0);
    vecs[9]  = mk(1,1,1,0,0,32'h0,        0,0,0,0,1,A0);
    vecs[10] = mk(1,1,1,0,0,32'h0,        0,0,0,0,1,A0);
    vecs[11] = mk(1,1,1,1,0,32'h0,        1,0,0,0,1,A0);
    vecs[12] = mk(1,0,1,1,1,32'hD000_000C,0,1,1,0,1,A1);
    vecs[13] = mk(1,0,0,0,1,32'hD000_000D,0,0,0,1,0,A0);
    // lock on m1 survives a switch to priority mode
    vecs[14] = mk(1,0,1,0,0,32'h0,        0,0,0,0,1,A1);
    vecs[15] = mk(0,1,1,0,0,32'h0,        0,0,0,0,1,A1);
    vecs[16] = mk(0,1,1,1,0,32'h0,        0,1,0,0,1,A1);
    // priority with starvation limit 4
    vecs[17] = mk(0,1,1,1,1,32'hD000_0011,1,0,0,1,1,A0);
    vecs[18] = mk(0,1,1,1,1,32'hD000_0012,1,0,1,0,1,A0);
    vecs[19] = mk(0,1,1,1,1,32'hD000_0013,1,0,1,0,1,A0);
    vecs[20] = mk(0,1,1,1,1,32'hD000_0014,1,0,1,0,1,A0);
    vecs[21] = mk(0,1,1,1,1,32'hD000_0015,0,1,1,0,1,A1);
    vecs[22] = mk(0,1,1,1,1,32'hD000_0016,1,0,0,1,1,A0);
    vecs[23] = mk(0,0,0,0,1,32'hD000_0017,0,0,1,0,0,A0);

    idle_inputs();
    mode_rr = 1;
    rst_n = 0;
    s_rv = 1; s_rdata = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("reset_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("reset_m0_rv",  {31'b0, m0_rv},  32'd0);
    chk("reset_m1_rv",  {31'b0, m1_rv},  32'd0);
    chk("reset_rdata_passthru", m1_rdata, 32'hFFFF_0000);
    rst_n = 1;
    s_rv = 0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      mode_rr = vecs[i].mode; m0_req = vecs[i].r0; m1_req = vecs[i].r1;
      s_gnt = vecs[i].gnt; s_rv = vecs[i].rv; s_rdata = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, vecs[i].g0});
      chk($sformatf("v%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, vecs[i].g1});
      chk($sformatf("v%0d_m0_rv", i),  {31'b0, m0_rv},  {31'b0, vecs[i].v0});
      chk($sformatf("v%0d_m1_rv", i),  {31'b0, m1_rv},  {31'b0, vecs[i].v1});
      chk($sformatf("v%0d_s_req", i),  {31'b0, s_req},  {31'b0, vecs[i].sreq});
      if (vecs[i].sreq) chk($sformatf("v%0d_s_add", i), s_add, vecs[i].sadd);
      if (vecs[i].v0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rdata);
      if (vecs[i].v1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].rdata);
    end

    // m1 write with partial byte enables
    @(negedge clk);
    idle_inputs();
    mode_rr = 1;
    m1_req = 1; m1_wen = 0; m1_wdata = 32'hDEAD_BEEF; m1_be = 4'b0011; s_gnt = 1;
    #2;
    chk("wr_m1_gnt",  {31'b0, m1_gnt}, 32'd1);
    chk("wr_s_wen",   {31'b0, s_wen},  32'd0);
    chk("wr_s_be",    {28'b0, s_be},   32'h3);
    chk("wr_s_wdata", s_wdata,         32'hDEAD_BEEF);
    @(negedge clk);
    m1_req = 0; s_gnt = 0; s_rv = 1;
    #2;
    chk("wr_m1_rv",  {31'b0, m1_rv}, 32'd1);
    chk("wr_m0_rv",  {31'b0, m0_rv}, 32'd0);
    @(negedge clk);
    #2;
    chk("wr_m1_rv_once", {31'b0, m1_rv}, 32'd0);

    // reset right after an m0 handshake
    @(negedge clk);
    idle_inputs();
    mode_rr = 1; m0_req = 1; s_gnt = 1;
    #2;
    chk("rst_pre_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    @(negedge clk);
    idle_inputs();
    rst_n = 0; s_rv = 1;
    #2;
    chk("rst_m0_rv", {31'b0, m0_rv}, 32'd0);
    chk("rst_m1_rv", {31'b0, m1_rv}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #2;
    chk("rst_after_m0_rv", {31'b0, m0_rv}, 32'd0);
    chk("rst_after_s_req", {31'b0, s_req}, 32'd0);
    @(negedge clk);
    s_rv = 0; m0_req = 1; m1_req = 1; s_gnt = 1;
    #2;
    chk("rst_rr_first_m0", {31'b0, m0_gnt}, 32'd1);
    chk("rst_rr_first_m1", {31'b0, m1_gnt}, 32'd0);
    chk("rst_rr_s_add",    s_add,           A0);
    @(negedge clk);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
